serial_comparator: RTL

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/serial_comparator.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_comparator.sv
// Serial MSB-first magnitude comparator for two unsigned operands.
// It stops at the first differing bit and reports gt/eq/lt and how many bit positions it examined.
module serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       bit_a,
  output logic                       bit_b,
  output logic                       done,
  output logic                       a_gt_b,
  output logic                       a_eq_b,
  output logic                       a_lt_b,
  output logic [$clog2(WIDTH+1)-1:0] bits_used
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] WIDTH_B = BW'(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [IW-1:0]    idx;
  logic             accept;
  logic             finish;
  logic             differ;

  // The MSB of each shift register always holds the bit at the current index.
  assign busy   = (state == SHIFT);
  assign bit_a  = (state == SHIFT) ? shift_a[WIDTH-1] : 1'b0;
  assign bit_b  = (state == SHIFT) ? shift_b[WIDTH-1] : 1'b0;
  assign differ = bit_a ^ bit_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (differ || (idx == IW'(0))) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Results are only written when a comparison finishes, so they survive a new start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_a   <= '0;
      shift_b   <= '0;
      idx       <= '0;
      done      <= 1'b0;
      a_gt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
      a_lt_b    <= 1'b0;
      bits_used <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        shift_a <= a;
        shift_b <= b;
        idx     <= IW'(WIDTH - 1);
      end else if ((state == SHIFT) && !finish) begin
        shift_a <= {shift_a[WIDTH-2:0], 1'b0};
        shift_b <= {shift_b[WIDTH-2:0], 1'b0};
        idx     <= idx - IW'(1);
      end
      if (finish) begin
        a_gt_b    <= differ & bit_a;
        a_lt_b    <= differ & ~bit_a;
        a_eq_b    <= ~differ;
        bits_used <= WIDTH_B - BW'(idx);
      end
    end
  end

endmodule
